// File: rtl/serv_dbg_pkg.sv
// Shared types and constants for the serv debug-entry/exit sequencer.
package serv_dbg_pkg;

   typedef enum logic [2:0] {
      StRun,
      StPend,
      StInj,
      StHalt,
      StExit,
      StStep
   } dbg_state_e;

   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_TRIG    = 3'd2;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/serv_dbg_stepcnt.sv
// Remaining-step counter: load (0 loads as 1), saturating decrement, clear.
module serv_dbg_stepcnt #(
   parameter int unsigned STEP_W = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [STEP_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic [STEP_W-1:0] o_cnt,
   output logic              o_zero,
   output logic              o_last
);

   localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   logic [STEP_W-1:0] cnt_q;
   logic [STEP_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_load) begin
         cnt_d = (i_load_val == '0) ? ONE : i_load_val;
      end else if (i_dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_zero = (cnt_q == '0);
   assign o_last = (cnt_q == ONE);

endmodule

// File: rtl/serv_dbg_seq.sv
// Debug-entry/exit sequencer: decides when to force ebreak into decode and tracks debug mode.
// Define SERV_DBG_TRIG_EN to enable the hardware trigger inputs.
module serv_dbg_seq
   import serv_dbg_pkg::*;
#(
   parameter int unsigned STEP_W     = 8,
   parameter int unsigned NTRIG      = 2,
   parameter int unsigned RESET_HALT = 0
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_wb_en,
   input  logic              i_cnt_done,
   input  logic              i_ebreak,
   input  logic              i_dret,
   input  logic              i_dbg_halt,
   input  logic              i_dbg_step,
   input  logic [STEP_W-1:0] i_step_cnt,
   input  logic [NTRIG-1:0]  i_trig,
   input  logic [NTRIG-1:0]  i_trig_en,
   output logic              o_inject,
   output logic              o_dbg_mode,
   output logic [2:0]        o_cause,
   output logic [STEP_W-1:0] o_steps_left,
   output logic              o_busy
);

   dbg_state_e state_q, state_d;
   logic [2:0] cause_q, cause_d;

   logic trig_hit;
   logic ebreak_done;
   logic cnt_load, cnt_dec, cnt_clr;
   logic cnt_zero, cnt_last;

`ifdef SERV_DBG_TRIG_EN
   assign trig_hit = |(i_trig & i_trig_en);
`else
   assign trig_hit = 1'b0;
   logic unused_trig;
   assign unused_trig = ^{i_trig, i_trig_en};
`endif

   assign ebreak_done = i_ebreak & i_cnt_done;

   // Priority within RUN/STEP: ebreak > trigger > haltreq
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      unique case (state_q)
         StRun: begin
            if (ebreak_done) begin
               state_d = StHalt;
               cause_d = CAUSE_EBREAK;
            end else if (trig_hit) begin
               state_d = StPend;
               cause_d = CAUSE_TRIG;
            end else if (i_dbg_halt) begin
               state_d = StPend;
               cause_d = CAUSE_HALTREQ;
            end
         end
         StPend: begin
            if (i_wb_en) state_d = StInj;
         end
         StInj: begin
            if (i_cnt_done) state_d = StHalt;
         end
         StHalt: begin
            // A step arriving with dret-done is loaded first so EXIT sees it
            cnt_load = i_dbg_step;
            if (i_dret && i_cnt_done) state_d = StExit;
         end
         StExit: begin
            state_d = cnt_zero ? StRun : StStep;
         end
         StStep: begin
            if (ebreak_done) begin
               state_d = StHalt;
               cause_d = CAUSE_EBREAK;
               cnt_clr = 1'b1;
            end else if (trig_hit) begin
               state_d = StPend;
               cause_d = CAUSE_TRIG;
               cnt_clr = 1'b1;
            end else if (i_dbg_halt) begin
               state_d = StPend;
               cause_d = CAUSE_HALTREQ;
               cnt_clr = 1'b1;
            end else if (i_cnt_done) begin
               cnt_dec = 1'b1;
               if (cnt_last || cnt_zero) begin
                  state_d = StPend;
                  cause_d = CAUSE_STEP;
               end
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= (RESET_HALT != 0) ? StPend : StRun;
         cause_q <= (RESET_HALT != 0) ? CAUSE_HALTREQ : CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   serv_dbg_stepcnt #(
      .STEP_W (STEP_W)
   ) u_stepcnt (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_clr      (cnt_clr),
      .i_load     (cnt_load),
      .i_load_val (i_step_cnt),
      .i_dec      (cnt_dec),
      .o_cnt      (o_steps_left),
      .o_zero     (cnt_zero),
      .o_last     (cnt_last)
   );

   assign o_inject   = (state_q == StPend);
   assign o_dbg_mode = (state_q == StHalt);
   assign o_busy     = (state_q == StPend) || (state_q == StInj) || (state_q == StExit);
   assign o_cause    = cause_q;

endmodule

// File: tb/tb_serv_dbg_seq.sv
// Bench for serv_dbg_seq: directed scenarios plus random stimulus against a flag-based model.
module tb_serv_dbg_seq;

   localparam int unsigned STEP_W = 8;
   localparam int unsigned NTRIG  = 2;

   logic              clk;
   logic              i_rst;
   logic              i_wb_en, i_cnt_done, i_ebreak, i_dret, i_dbg_halt, i_dbg_step;
   logic [STEP_W-1:0] i_step_cnt;
   logic [NTRIG-1:0]  i_trig, i_trig_en;

   logic              o_inject, o_dbg_mode, o_busy;
   logic [2:0]        o_cause;
   logic [STEP_W-1:0] o_steps_left;

   logic              rh_inject, rh_dbg_mode, rh_busy;
   logic [2:0]        rh_cause;
   logic [STEP_W-1:0] rh_steps_left;

   int vectors;
   int miscompares;
   bit cmp_en;

   // Model: mode flags, remaining steps and cause
   bit m_pend, m_inj, m_halted, m_exiting, m_stepping;
   int m_steps;
   int m_cause;

   serv_dbg_seq #(
      .STEP_W     (STEP_W),
      .NTRIG      (NTRIG),
      .RESET_HALT (0)
   ) dut (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_wb_en      (i_wb_en),
      .i_cnt_done   (i_cnt_done),
      .i_ebreak     (i_ebreak),
      .i_dret       (i_dret),
      .i_dbg_halt   (i_dbg_halt),
      .i_dbg_step   (i_dbg_step),
      .i_step_cnt   (i_step_cnt),
      .i_trig       (i_trig),
      .i_trig_en    (i_trig_en),
      .o_inject     (o_inject),
      .o_dbg_mode   (o_dbg_mode),
      .o_cause      (o_cause),
      .o_steps_left (o_steps_left),
      .o_busy       (o_busy)
   );

   serv_dbg_seq #(
      .STEP_W     (STEP_W),
      .NTRIG      (NTRIG),
      .RESET_HALT (1)
   ) dut_rh (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_wb_en      (i_wb_en),
      .i_cnt_done   (i_cnt_done),
      .i_ebreak     (i_ebreak),
      .i_dret       (i_dret),
      .i_dbg_halt   (i_dbg_halt),
      .i_dbg_step   (i_dbg_step),
      .i_step_cnt   (i_step_cnt),
      .i_trig       (i_trig),
      .i_trig_en    (i_trig_en),
      .o_inject     (rh_inject),
      .o_dbg_mode   (rh_dbg_mode),
      .o_cause      (rh_cause),
      .o_steps_left (rh_steps_left),
      .o_busy       (rh_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_inj = 0; m_halted = 0; m_exiting = 0; m_stepping = 0;
      m_steps = 0;
      m_cause = 0;
   endtask

   task automatic model_update();
      bit ebd, trig;
      ebd = i_ebreak && i_cnt_done;
`ifdef SERV_DBG_TRIG_EN
      trig = (i_trig & i_trig_en) != 0;
`else
      trig = 0;
`endif
      if (m_pend) begin
         if (i_wb_en) begin m_pend = 0; m_inj = 1; end
      end else if (m_inj) begin
         if (i_cnt_done) begin m_inj = 0; m_halted = 1; end
      end else if (m_halted) begin
         if (i_dbg_step) m_steps = (i_step_cnt == 0) ? 1 : int'(i_step_cnt);
         if (i_dret && i_cnt_done) begin m_halted = 0; m_exiting = 1; end
      end else if (m_exiting) begin
         m_exiting  = 0;
         m_stepping = (m_steps != 0);
      end else if (m_stepping) begin
         if (ebd) begin
            m_stepping = 0; m_halted = 1; m_cause = 1; m_steps = 0;
         end else if (trig) begin
            m_stepping = 0; m_pend = 1; m_cause = 2; m_steps = 0;
         end else if (i_dbg_halt) begin
            m_stepping = 0; m_pend = 1; m_cause = 3; m_steps = 0;
         end else if (i_cnt_done) begin
            if (m_steps > 0) m_steps = m_steps - 1;
            if (m_steps == 0) begin m_stepping = 0; m_pend = 1; m_cause = 4; end
         end
      end else begin
         if (ebd) begin
            m_halted = 1; m_cause = 1;
         end else if (trig) begin
            m_pend = 1; m_cause = 2;
         end else if (i_dbg_halt) begin
            m_pend = 1; m_cause = 3;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!i_rst) model_update();
      #1;
      i_wb_en = 0; i_cnt_done = 0; i_ebreak = 0; i_dret = 0; i_dbg_step = 0;
      i_trig = '0;
   endtask

   always @(negedge clk) begin
      if (cmp_en && !i_rst) begin
         check("inject", int'(o_inject), int'(m_pend));
         check("dbg_mode", int'(o_dbg_mode), int'(m_halted));
         check("busy", int'(o_busy), int'(m_pend || m_inj || m_exiting));
         check("cause", int'(o_cause), m_cause);
         check("steps_left", int'(o_steps_left), m_steps);
      end
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      cmp_en = 0;
      i_rst = 1;
      i_wb_en = 0; i_cnt_done = 0; i_ebreak = 0; i_dret = 0; i_dbg_halt = 0;
      i_dbg_step = 0; i_step_cnt = '0; i_trig = '0; i_trig_en = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 i_rst = 0;
      #1;
      check("rst_inject", int'(o_inject), 0);
      check("rst_mode", int'(o_dbg_mode), 0);
      check("rst_cause", int'(o_cause), 0);
      check("rst_steps", int'(o_steps_left), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rh_inject", int'(rh_inject), 1);
      check("rh_cause", int'(rh_cause), 3);
      check("rh_mode", int'(rh_dbg_mode), 0);
      cmp_en = 1;

      // Halt request, injection held for three cycles before decode accepts
      i_dbg_halt = 1; tick();
      check("halt_inj0", int'(o_inject), 1);
      tick(); check("halt_inj1", int'(o_inject), 1);
      tick(); check("halt_inj2", int'(o_inject), 1);
      i_wb_en = 1; tick();
      check("inj_drop", int'(o_inject), 0);
      check("inj_busy", int'(o_busy), 1);
      i_dbg_halt = 0;
      i_cnt_done = 1; tick();
      check("halt_mode", int'(o_dbg_mode), 1);
      check("halt_cause", int'(o_cause), 3);

      // Three-step run
      i_dbg_step = 1; i_step_cnt = 8'd3; tick();
      check("step_load", int'(o_steps_left), 3);
      i_dret = 1; i_cnt_done = 1; tick();
      check("exit_mode", int'(o_dbg_mode), 0);
      check("exit_busy", int'(o_busy), 1);
      tick();
      check("step_cnt3", int'(o_steps_left), 3);
      i_cnt_done = 1; tick(); check("step_cnt2", int'(o_steps_left), 2);
      i_cnt_done = 1; tick(); check("step_cnt1", int'(o_steps_left), 1);
      i_cnt_done = 1; tick(); check("step_cnt0", int'(o_steps_left), 0);
      check("step_pend", int'(o_inject), 1);
      check("step_cause", int'(o_cause), 4);
      i_wb_en = 1; tick();
      i_cnt_done = 1; tick();
      check("step_reenter", int'(o_dbg_mode), 1);

      // Step count 0 behaves as 1, loaded together with dret-done
      i_dbg_step = 1; i_step_cnt = 8'd0; i_dret = 1; i_cnt_done = 1; tick();
      check("step0_load", int'(o_steps_left), 1);
      tick();
      i_cnt_done = 1; tick();
      check("step0_pend", int'(o_inject), 1);
      check("step0_cause", int'(o_cause), 4);
      i_wb_en = 1; tick();
      i_cnt_done = 1; tick();

      // Plain exit to RUN
      i_dret = 1; i_cnt_done = 1; tick();
      tick();
      check("run_mode", int'(o_dbg_mode), 0);
      check("run_busy", int'(o_busy), 0);

      // Software ebreak
      i_ebreak = 1; i_cnt_done = 1; tick();
      check("ebrk_mode", int'(o_dbg_mode), 1);
      check("ebrk_cause", int'(o_cause), 1);
      check("ebrk_noinj", int'(o_inject), 0);
      i_dret = 1; i_cnt_done = 1; tick();
      tick();

      // Triggers
      i_trig_en = 2'b10; i_trig = 2'b10; tick();
`ifdef SERV_DBG_TRIG_EN
      check("trig_inj", int'(o_inject), 1);
      check("trig_cause", int'(o_cause), 2);
      i_wb_en = 1; tick();
      i_cnt_done = 1; tick();
      i_dret = 1; i_cnt_done = 1; tick();
      tick();
`else
      check("trig_off", int'(o_inject), 0);
`endif
      i_trig_en = 2'b00; i_trig = 2'b10; tick();
      check("trig_dis", int'(o_inject), 0);

      // Async reset during injection
      i_dbg_halt = 1; tick();
      i_dbg_halt = 0; i_wb_en = 1; tick();
      check("pre_rst_busy", int'(o_busy), 1);
      #2;
      i_rst = 1;
      model_reset();
      #1;
      check("arst_inject", int'(o_inject), 0);
      check("arst_mode", int'(o_dbg_mode), 0);
      check("arst_busy", int'(o_busy), 0);
      @(posedge clk);
      #2 i_rst = 0;
      #1;
      check("rh_inject2", int'(rh_inject), 1);
      check("rh_cause2", int'(rh_cause), 3);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         i_wb_en    = ($urandom % 3) == 0;
         i_cnt_done = ($urandom % 3) == 0;
         i_ebreak   = ($urandom % 16) == 0;
         i_dret     = ($urandom % 5) == 0;
         i_dbg_step = ($urandom % 6) == 0;
         i_step_cnt = (($urandom % 8) == 0) ? STEP_W'($urandom_range(0, 20))
                                             : STEP_W'($urandom % 4);
         i_trig     = (($urandom % 10) == 0) ? NTRIG'($urandom) : '0;
         i_trig_en  = NTRIG'($urandom);
         if (($urandom % 25) == 0) i_dbg_halt = ~i_dbg_halt;
         tick();
      end

      cmp_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
